// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem
// AHB-Lite slave responder backed by a word-addressed memory. It produces the
// hrdata/hreadyout/hresp set that the slave-to-master multiplexer selects, and
// inserts a fixed number of wait states into every OKAY data phase.
//
// Optional build macro: AHB_SLAVE_ERR_EN
//   defined   : a transfer with non-zero address bits above the memory or with
//               hsize > word gets a two-cycle ERROR response and no write.
//   undefined : no ERROR states, hresp tied low, address wraps modulo
//               MEM_DEPTH and oversized hsize is treated as a word.
//
// Ports
//   hclk      in   bus clock, rising edge
//   hresetn   in   synchronous active-low reset
//   hsel      in   slave select from the decoder
//   haddr     in   transfer address (byte address)
//   htrans    in   IDLE/BUSY/NONSEQ/SEQ
//   hwrite    in   1 = write
//   hsize     in   byte/halfword/word
//   hwdata    in   write data, valid in the data phase
//   hready    in   bus-level ready from the multiplexer
//   hrdata    out  read data, zero outside a read data phase
//   hreadyout out  slave ready
//   hresp     out  0 OKAY, 1 ERROR
module ahb_slave_mem #(
  parameter int MEM_DEPTH   = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData
`ifdef AHB_SLAVE_ERR_EN
    , StErr1
    , StErr2
`endif
  } state_e;

  // Value of the wait counter on the last wait cycle; unused when there are
  // no wait states because WAIT is then never entered.
  localparam logic [3:0] LastWait = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          waitCnt_q, waitCnt_d;
  logic [ADDR_W+1:0]   addr_q;
  logic                write_q;
  logic [2:0]          size_q;

  logic [31:0]         mem [MEM_DEPTH];

  logic                addrOpen;
  logic                accept;
  logic                badXfer;
  logic [ADDR_W-1:0]   wordIdx;
  logic [3:0]          laneEn;
  logic                unusedBits;

  // htrans[0] only distinguishes BUSY/SEQ, which behave like IDLE/NONSEQ here;
  // the upper address bits matter only when the error check is built in.
  assign unusedBits = ^{htrans[0], haddr[31:ADDR_W+2]};

  // A new address phase can only be taken when this slave is not stalling
  // the bus: idle, or on the final cycle of a data phase.
`ifdef AHB_SLAVE_ERR_EN
  assign addrOpen = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign badXfer  = (|haddr[31:ADDR_W+2]) || (hsize > 3'b010);
`else
  assign addrOpen = (state_q == StIdle) || (state_q == StData);
  assign badXfer  = 1'b0;
`endif

  assign accept  = addrOpen && hsel && hready && htrans[1];
  assign wordIdx = addr_q[ADDR_W+1:2];

  // Byte lanes are little-endian; low address bits below the access size are
  // ignored so misaligned halfwords/words snap to their natural lanes.
  always_comb begin
    laneEn = 4'b1111;
    case (size_q)
      3'b000:  laneEn = 4'b0001 << addr_q[1:0];
      3'b001:  laneEn = addr_q[1] ? 4'b1100 : 4'b0011;
      default: laneEn = 4'b1111;
    endcase
  end

  // Next-state and handshake outputs. The last cycle of every data phase
  // doubles as an address phase, so the pipelined transfer is picked up here.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_q)
      StIdle: ;
      StWait: begin
        hreadyout = 1'b0;
        if (waitCnt_q == LastWait) begin
          state_d   = StData;
          waitCnt_d = 4'd0;
        end else begin
          waitCnt_d = waitCnt_q + 4'd1;
        end
      end
      StData: ;
`ifdef AHB_SLAVE_ERR_EN
      StErr1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = StErr2;
      end
      StErr2: hresp = 1'b1;
`endif
      default: state_d = StIdle;
    endcase
    if (addrOpen) begin
      state_d = StIdle;
      if (accept) begin
        waitCnt_d = 4'd0;
        if (badXfer)
          state_d = state_e'(3'd3);
        else if (WAIT_STATES > 0)
          state_d = StWait;
        else
          state_d = StData;
      end
    end
  end

  // State register plus the address-phase latch.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q   <= StIdle;
      waitCnt_q <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= 3'b000;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      if (accept) begin
        addr_q  <= haddr[ADDR_W+1:0];
        write_q <= hwrite;
        size_q  <= hsize;
      end
    end
  end

  // Writes commit at the edge that ends DATA; a reset on that edge aborts it.
  // The memory itself is never cleared.
  always_ff @(posedge hclk) begin
    if (hresetn && (state_q == StData) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (laneEn[b])
          mem[wordIdx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  // Reads return the whole word combinationally, so a write committed on the
  // previous edge is already visible to a back-to-back read.
  assign hrdata = ((state_q == StData) && !write_q) ? mem[wordIdx] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem
// Three slaves with 0, 2 and 3 wait states are driven independently. A
// transaction-level model tracks each slave's outstanding data phase and a
// byte-wise image of its memory, and one compare process checks every output
// of every slave on each falling edge. Directed sequences pin the model with
// hand-computed values, then random traffic runs against it.
module tb_ahb_slave_mem;

  logic        hclk;
  logic        hresetn;
  logic        checkOn;
  int          checks;
  int          errors;

  logic        hsel      [3];
  logic [31:0] haddr     [3];
  logic [1:0]  htrans    [3];
  logic        hwrite    [3];
  logic [2:0]  hsize     [3];
  logic        extReady  [3];
  logic [31:0] wdataNext [3];
  logic [31:0] hwdata    [3];
  logic        hready    [3];
  logic [31:0] hrdata    [3];
  logic        hreadyout [3];
  logic        hresp     [3];

  logic        mPend    [3];
  logic        mWrite   [3];
  logic        mErr     [3];
  logic        mAcc     [3];
  logic [31:0] mAddr    [3];
  logic [2:0]  mSize    [3];
  logic [31:0] mWdata   [3];
  int          mElapsed [3];
  logic [31:0] mMem     [3][256];
  logic [3:0]  mKnown   [3][256];

  logic        expReady [3];
  logic        expResp  [3];
  logic [31:0] expRdata [3];
  logic [31:0] expMask  [3];

  function automatic int wsOf(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic logic isErr(input logic [31:0] a, input logic [2:0] s);
`ifdef AHB_SLAVE_ERR_EN
    return (a >= 32'd1024) || (s > 3'd2);
`else
    return 1'b0;
`endif
  endfunction

  // Whether byte lane b is written by an access of size s at byte address a.
  function automatic logic laneOn(input int b, input logic [31:0] a, input logic [2:0] s);
    int off;
    off = int'(a % 4);
    if (s == 3'd0) return b == off;
    if (s == 3'd1) return (b / 2) == (off / 2);
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gSlave
    assign hready[g] = mPend[g] ? expReady[g] : extReady[g];
    assign hwdata[g] = (mPend[g] && mWrite[g]) ? mWdata[g] : 32'hBADC0DE0;

    ahb_slave_mem #(
      .MEM_DEPTH(256),
      .ADDR_W(8),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) dut (
      .hclk(hclk),
      .hresetn(hresetn),
      .hsel(hsel[g]),
      .haddr(haddr[g]),
      .htrans(htrans[g]),
      .hwrite(hwrite[g]),
      .hsize(hsize[g]),
      .hwdata(hwdata[g]),
      .hready(hready[g]),
      .hrdata(hrdata[g]),
      .hreadyout(hreadyout[g]),
      .hresp(hresp[g])
    );
  end

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Model update: retire the outstanding data phase, then take a new one.
  always @(posedge hclk) begin
    for (int k = 0; k < 3; k++) begin
      mAcc[k] <= 1'b0;
      if (!hresetn) begin
        mPend[k] <= 1'b0;
      end else begin
        if (mPend[k]) begin
          if (mErr[k]) begin
            if (mElapsed[k] == 1) mPend[k] <= 1'b0;
            else mElapsed[k] <= mElapsed[k] + 1;
          end else if (mElapsed[k] == wsOf(k)) begin
            mPend[k] <= 1'b0;
            if (mWrite[k]) begin
              for (int b = 0; b < 4; b++) begin
                if (laneOn(b, mAddr[k], mSize[k])) begin
                  mMem[k][mAddr[k][9:2]][8*b +: 8] <= hwdata[k][8*b +: 8];
                  mKnown[k][mAddr[k][9:2]][b] <= 1'b1;
                end
              end
            end
          end else begin
            mElapsed[k] <= mElapsed[k] + 1;
          end
        end
        if (hready[k] && hsel[k] && htrans[k][1]) begin
          mAcc[k]     <= 1'b1;
          mPend[k]    <= 1'b1;
          mElapsed[k] <= 0;
          mWrite[k]   <= hwrite[k];
          mAddr[k]    <= haddr[k];
          mSize[k]    <= hsize[k];
          mWdata[k]   <= wdataNext[k];
          mErr[k]     <= isErr(haddr[k], hsize[k]);
        end
      end
    end
  end

  // Expected outputs from the model's view of the outstanding data phase.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      expReady[k] = 1'b1;
      expResp[k]  = 1'b0;
      expRdata[k] = 32'h0;
      expMask[k]  = 32'hFFFFFFFF;
      if (mPend[k]) begin
        if (mErr[k]) begin
          expReady[k] = (mElapsed[k] == 1);
          expResp[k]  = 1'b1;
        end else begin
          expReady[k] = (mElapsed[k] == wsOf(k));
          if (expReady[k] && !mWrite[k]) begin
            expRdata[k] = mMem[k][mAddr[k][9:2]];
            for (int b = 0; b < 4; b++)
              expMask[k][8*b +: 8] = {8{mKnown[k][mAddr[k][9:2]][b]}};
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected, input logic [31:0] mask);
    checks++;
    if ((actual & mask) !== (expected & mask)) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (mask %h) at %0t", name, actual, expected, mask, $time);
    end
  endtask

  always @(negedge hclk) begin
    if (checkOn) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("hreadyout[%0d]", k), {31'b0, hreadyout[k]}, {31'b0, expReady[k]}, 32'h1);
        checkOutput($sformatf("hresp[%0d]", k), {31'b0, hresp[k]}, {31'b0, expResp[k]}, 32'h1);
        checkOutput($sformatf("hrdata[%0d]", k), hrdata[k], expRdata[k], expMask[k]);
      end
    end
  end

  task automatic applyStimulus(input int k, input logic sel, input logic [1:0] trans,
                               input logic [31:0] addr, input logic wr, input logic [2:0] size,
                               input logic [31:0] wd, input logic rdy);
    hsel[k]      = sel;
    htrans[k]    = trans;
    haddr[k]     = addr;
    hwrite[k]    = wr;
    hsize[k]     = size;
    wdataNext[k] = wd;
    extReady[k]  = rdy;
  endtask

  task automatic idleAll();
    for (int k = 0; k < 3; k++) applyStimulus(k, 1'b0, 2'b00, 32'h0, 1'b0, 3'b010, 32'h0, 1'b1);
  endtask

  // Present an address phase and hold it until the slave takes it.
  task automatic issue(input int k, input logic wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wd);
    int n;
    applyStimulus(k, 1'b1, 2'b10, addr, wr, size, wd, 1'b1);
    n = 0;
    do begin
      @(posedge hclk); #1;
      n++;
    end while (!mAcc[k] && n < 50);
    checkOutput($sformatf("accept[%0d]", k), {31'b0, mAcc[k]}, 32'h1, 32'h1);
  endtask

  task automatic readWord(input int k, input logic [31:0] addr,
                          output logic [31:0] data, output int lows);
    issue(k, 1'b0, addr, 3'b010, 32'h0);
    applyStimulus(k, 1'b0, 2'b00, 32'h0, 1'b0, 3'b010, 32'h0, 1'b1);
    lows = 0;
    @(negedge hclk);
    while (hreadyout[k] !== 1'b1 && lows < 40) begin
      lows++;
      @(negedge hclk);
    end
    data = hrdata[k];
    @(posedge hclk); #1;
  endtask

  task automatic ignoredCycle(input int k, input logic sel, input logic [1:0] trans, input logic rdy);
    applyStimulus(k, sel, trans, 32'h4, 1'b1, 3'b010, 32'h0BAD0BAD, rdy);
    @(negedge hclk);
    checkOutput("ignored hreadyout", {31'b0, hreadyout[k]}, 32'h1, 32'h1);
    @(posedge hclk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    int          lows;
    checks  = 0;
    errors  = 0;
    checkOn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mPend[k] = 1'b0; mAcc[k] = 1'b0; mWrite[k] = 1'b0; mErr[k] = 1'b0;
      mAddr[k] = 32'h0; mSize[k] = 3'd0; mWdata[k] = 32'h0; mElapsed[k] = 0;
      for (int i = 0; i < 256; i++) begin
        mKnown[k][i] = 4'h0;
        mMem[k][i]   = 32'h0;
      end
    end
    idleAll();
    hresetn = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    checkOn = 1'b1;
    checkOutput("reset hreadyout", {31'b0, hreadyout[0]}, 32'h1, 32'h1);
    checkOutput("reset hresp", {31'b0, hresp[0]}, 32'h0, 32'h1);
    checkOutput("reset hrdata", hrdata[0], 32'h0, 32'hFFFFFFFF);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    $display("[TB] back-to-back write/read, no wait states");
    issue(0, 1'b1, 32'h04, 3'b010, 32'hDEADBEEF);
    readWord(0, 32'h04, rd, lows);
    checkOutput("b2b read data", rd, 32'hDEADBEEF, 32'hFFFFFFFF);
    checkOutput("b2b wait cycles", lows, 32'd0, 32'hFFFFFFFF);

    $display("[TB] byte lanes");
    issue(0, 1'b1, 32'h20, 3'b010, 32'h00000000);
    issue(0, 1'b1, 32'h21, 3'b000, 32'h0000AA00);
    issue(0, 1'b1, 32'h22, 3'b001, 32'h12340000);
    readWord(0, 32'h20, rd, lows);
    checkOutput("lane merge", rd, 32'h1234AA00, 32'hFFFFFFFF);

    $display("[TB] ignored cycles");
    ignoredCycle(0, 1'b1, 2'b01, 1'b1);
    ignoredCycle(0, 1'b1, 2'b00, 1'b1);
    ignoredCycle(0, 1'b0, 2'b10, 1'b1);
    ignoredCycle(0, 1'b1, 2'b10, 1'b0);
    readWord(0, 32'h04, rd, lows);
    checkOutput("ignored no write", rd, 32'hDEADBEEF, 32'hFFFFFFFF);
    checkOutput("ignored no wait", lows, 32'd0, 32'hFFFFFFFF);

    $display("[TB] three wait states");
    issue(2, 1'b1, 32'h08, 3'b010, 32'hCAFEF00D);
    readWord(2, 32'h08, rd, lows);
    checkOutput("ws3 read data", rd, 32'hCAFEF00D, 32'hFFFFFFFF);
    checkOutput("ws3 wait cycles", lows, 32'd3, 32'hFFFFFFFF);

    $display("[TB] reset during wait");
    issue(1, 1'b1, 32'h10, 3'b010, 32'h11111111);
    readWord(1, 32'h10, rd, lows);
    checkOutput("ws2 read data", rd, 32'h11111111, 32'hFFFFFFFF);
    checkOutput("ws2 wait cycles", lows, 32'd2, 32'hFFFFFFFF);
    issue(1, 1'b1, 32'h10, 3'b010, 32'h55555555);
    applyStimulus(1, 1'b0, 2'b00, 32'h0, 1'b0, 3'b010, 32'h0, 1'b1);
    hresetn = 1'b0;
    repeat (2) begin
      @(posedge hclk); #1;
    end
    checkOutput("mid-wait reset hreadyout", {31'b0, hreadyout[1]}, 32'h1, 32'h1);
    checkOutput("mid-wait reset hresp", {31'b0, hresp[1]}, 32'h0, 32'h1);
    checkOutput("mid-wait reset hrdata", hrdata[1], 32'h0, 32'hFFFFFFFF);
    hresetn = 1'b1;
    @(posedge hclk); #1;
    readWord(1, 32'h10, rd, lows);
    checkOutput("aborted write", rd, 32'h11111111, 32'hFFFFFFFF);

    $display("[TB] out-of-range address");
    issue(0, 1'b1, 32'h00, 3'b010, 32'hA5A5A5A5);
    issue(0, 1'b1, 32'h400, 3'b010, 32'h5A5A5A5A);
    applyStimulus(0, 1'b0, 2'b00, 32'h0, 1'b0, 3'b010, 32'h0, 1'b1);
    @(negedge hclk);
`ifdef AHB_SLAVE_ERR_EN
    checkOutput("err cycle1 hreadyout", {31'b0, hreadyout[0]}, 32'h0, 32'h1);
    checkOutput("err cycle1 hresp", {31'b0, hresp[0]}, 32'h1, 32'h1);
    @(negedge hclk);
    checkOutput("err cycle2 hreadyout", {31'b0, hreadyout[0]}, 32'h1, 32'h1);
    checkOutput("err cycle2 hresp", {31'b0, hresp[0]}, 32'h1, 32'h1);
    @(posedge hclk); #1;
    readWord(0, 32'h00, rd, lows);
    checkOutput("err no write", rd, 32'hA5A5A5A5, 32'hFFFFFFFF);
`else
    checkOutput("wrap hreadyout", {31'b0, hreadyout[0]}, 32'h1, 32'h1);
    checkOutput("wrap hresp", {31'b0, hresp[0]}, 32'h0, 32'h1);
    @(posedge hclk); #1;
    readWord(0, 32'h00, rd, lows);
    checkOutput("wrap write", rd, 32'h5A5A5A5A, 32'hFFFFFFFF);
`endif

    $display("[TB] random traffic");
    repeat (3000) begin
      for (int k = 0; k < 3; k++) begin
        logic [31:0] a;
        logic [2:0]  s;
        a = {24'h0, 4'($urandom_range(0, 15)), 2'b00, 2'($urandom)};
        if ($urandom_range(0, 7) == 0) a[10 + $urandom_range(0, 21)] = 1'b1;
        s = 3'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) s = 3'd5;
        applyStimulus(k, $urandom_range(0, 3) != 0, 2'($urandom), a, 1'($urandom), s,
                      $urandom, $urandom_range(0, 4) != 0);
      end
      @(posedge hclk); #1;
    end
    idleAll();
    repeat (10) @(posedge hclk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
